// File: rtl/load_return_unit.sv
// MEM-stage load path: alignment check, data-memory or peripheral-bridge read,
// little-endian lane extraction with sign/zero extension, pipeline stall and error reporting.
module load_return_unit #(
  parameter logic [15:0] DEV_BASE = 16'h7F00,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [2:0]  ld_sel,
  input  logic [31:0] addr,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready,
  output logic        dev_req,
  output logic [31:0] dev_addr,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        stall,
  output logic        adel,
  output logic        dbe
);

  typedef enum logic [1:0] {IDLE, DM_WAIT, DEV_WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dev_req_q, dev_req_d;
  logic [31:0] dev_addr_q, dev_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        dbe_q, dbe_d;

  logic is_byte, is_half, is_word, in_dev, misaligned, req_ok;

  // Lane selection mirrors the store byte-enables: offset 0 is bits [7:0].
  function automatic logic [31:0] extract(input logic [2:0] sel, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sel)
      3'b001:  extract = {24'b0, b};
      3'b010:  extract = {{24{b[7]}}, b};
      3'b011:  extract = {16'b0, h};
      3'b100:  extract = {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    is_byte    = (ld_sel == 3'b001) || (ld_sel == 3'b010);
    is_half    = (ld_sel == 3'b011) || (ld_sel == 3'b100);
    is_word    = ~is_byte & ~is_half;
    in_dev     = (addr[31:16] == DEV_BASE);
    // The bridge only carries full words, so any narrower access there is an address error.
    misaligned = (is_half & addr[0]) | (is_word & (|addr[1:0])) | (~is_word & in_dev);
    req_ok     = ld_en & ~flush;
    adel       = (state_q == IDLE) & req_ok & misaligned;
    stall      = (state_q == IDLE) ? (req_ok & ~misaligned) : 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    dev_req_d  = dev_req_q;
    dev_addr_d = dev_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    dbe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok && !misaligned) begin
          sel_d = ld_sel;
          off_d = addr[1:0];
          if (in_dev) begin
            dev_addr_d = {addr[31:2], 2'b00};
            dev_req_d  = 1'b1;
            cnt_d      = 8'd0;
            state_d    = DEV_WAIT;
          end else begin
            state_d = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        state_d = IDLE;
        if (!flush) begin
          wb_data_d  = extract(sel_q, off_q, dm_rdata);
          wb_valid_d = 1'b1;
        end
      end
      DEV_WAIT: begin
        if (flush) begin
          dev_req_d = 1'b0;
          state_d   = IDLE;
        end else if (dev_ready) begin
          wb_data_d  = extract(sel_q, off_q, dev_rdata);
          wb_valid_d = 1'b1;
          dev_req_d  = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          wb_data_d = 32'd0;
          dbe_d     = 1'b1;
          dev_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= 8'd0;
      dev_req_q  <= 1'b0;
      dev_addr_q <= 32'd0;
      wb_data_q  <= 32'd0;
      wb_valid_q <= 1'b0;
      dbe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      dev_req_q  <= dev_req_d;
      dev_addr_q <= dev_addr_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      dbe_q      <= dbe_d;
    end
  end

  assign dev_req  = dev_req_q;
  assign dev_addr = dev_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_valid = wb_valid_q;
  assign dbe      = dbe_q;

endmodule

// File: tb/tb_load_return_unit.sv
// Bench for load_return_unit: vector table of DM loads, hand-written device,
// timeout, flush and reset sequences; write-back results checked through a queue.
module tb_load_return_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, flush, ld_en, dev_ready;
  logic [2:0]  ld_sel;
  logic [31:0] addr, dm_rdata, dev_rdata;
  logic        dev_req, wb_valid, stall, adel, dbe;
  logic [31:0] dev_addr, wb_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] word;
    logic        adel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        is_dbe;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];

  load_return_unit #(.DEV_BASE(16'h7F00), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ld_en(ld_en), .ld_sel(ld_sel),
    .addr(addr), .dm_rdata(dm_rdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .dev_req(dev_req), .dev_addr(dev_addr), .wb_data(wb_data), .wb_valid(wb_valid),
    .stall(stall), .adel(adel), .dbe(dbe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write-back or bus-error pulse is matched against the oldest expected result.
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (wb_valid || dbe) begin
      chk("wb_valid_dbe_exclusive", 32'(wb_valid & dbe), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result t=%0t wb_valid=%0b dbe=%0b wb_data=%h required=none",
                 $time, wb_valid, dbe, wb_data);
      end else begin
        e = sb_q.pop_front();
        $display("result t=%0t wb_valid=%0b dbe=%0b wb_data=%h", $time, wb_valid, dbe, wb_data);
        chk("result_is_dbe", 32'(dbe), 32'(e.is_dbe));
        chk("result_wb_data", wb_data, e.data);
      end
    end
  end

  task automatic dm_load(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] word,
                         input logic exp_adel, input logic [31:0] exp);
    step();
    ld_en = 1'b1; ld_sel = sel; addr = a; #1;
    chk("dm_adel_T", 32'(adel), 32'(exp_adel));
    chk("dm_stall_T", 32'(stall), 32'(!exp_adel));
    if (!exp_adel) sb_q.push_back('{1'b0, exp});
    step();
    ld_en = 1'b0; dm_rdata = word; #1;
    chk("dm_stall_T1", 32'(stall), 32'(!exp_adel));
    chk("dm_wb_valid_T1", 32'(wb_valid), 32'd0);
    step();
    dm_rdata = 32'h5A5A_5A5A; #1;
    chk("dm_wb_valid_T2", 32'(wb_valid), 32'(!exp_adel));
    chk("dm_stall_T2", 32'(stall), 32'd0);
  endtask

  // rc: DEV_WAIT cycle index (0 = first) in which dev_ready rises; negative = never.
  task automatic dev_lw(input int rc, input logic [31:0] data);
    step();
    ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h7F00_0004; #1;
    chk("dev_adel_T", 32'(adel), 32'd0);
    chk("dev_stall_T", 32'(stall), 32'd1);
    if (rc < 0) sb_q.push_back('{1'b1, 32'd0});
    else        sb_q.push_back('{1'b0, data});
    for (int i = 0; i < TO; i++) begin
      step();
      ld_en = 1'b0;
      dev_ready = (i == rc);
      dev_rdata = (i == rc) ? data : 32'h0BAD_0BAD;
      #1;
      chk("dev_req_wait", 32'(dev_req), 32'd1);
      chk("dev_addr", dev_addr, 32'h7F00_0004);
      chk("dev_stall_wait", 32'(stall), 32'd1);
      chk("dev_dbe_wait", 32'(dbe), 32'd0);
      chk("dev_wb_valid_wait", 32'(wb_valid), 32'd0);
      if (i == rc) break;
    end
    step();
    dev_ready = 1'b0; #1;
    chk("dev_wb_valid_end", 32'(wb_valid), 32'(rc >= 0));
    chk("dev_dbe_end", 32'(dbe), 32'(rc < 0));
    chk("dev_req_end", 32'(dev_req), 32'd0);
    chk("dev_stall_end", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b010, 32'h0000_0003, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{3'b001, 32'h0000_0003, 32'h80FF_1234, 1'b0, 32'h0000_0080};
    vecs[2]  = '{3'b100, 32'h0000_0002, 32'h8001_F00F, 1'b0, 32'hFFFF_8001};
    vecs[3]  = '{3'b011, 32'h0000_0000, 32'h8001_F00F, 1'b0, 32'h0000_F00F};
    vecs[4]  = '{3'b000, 32'h0000_0001, 32'h8001_F00F, 1'b1, 32'h0000_0000};
    vecs[5]  = '{3'b010, 32'h0000_0001, 32'h80FF_1234, 1'b0, 32'h0000_0012};
    vecs[6]  = '{3'b010, 32'h0000_0000, 32'h80FF_1234, 1'b0, 32'h0000_0034};
    vecs[7]  = '{3'b001, 32'h0000_0002, 32'h80FF_1234, 1'b0, 32'h0000_00FF};
    vecs[8]  = '{3'b010, 32'h0000_0002, 32'h80FF_1234, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{3'b100, 32'h0000_0003, 32'h80FF_1234, 1'b1, 32'h0000_0000};
    vecs[10] = '{3'b011, 32'h0000_0001, 32'h80FF_1234, 1'b1, 32'h0000_0000};
    vecs[11] = '{3'b000, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[12] = '{3'b101, 32'h0000_0004, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF};
    vecs[13] = '{3'b111, 32'h0000_0002, 32'h1357_9BDF, 1'b1, 32'h0000_0000};
    vecs[14] = '{3'b100, 32'h0000_0000, 32'h0000_7FFF, 1'b0, 32'h0000_7FFF};
    vecs[15] = '{3'b011, 32'h0000_0012, 32'hBEEF_0001, 1'b0, 32'h0000_BEEF};

    reset = 1'b1; flush = 1'b0; ld_en = 1'b0; dev_ready = 1'b0;
    ld_sel = 3'b000; addr = 32'd0; dm_rdata = 32'd0; dev_rdata = 32'd0;
    #20;
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_dev_req", 32'(dev_req), 32'd0);
    chk("reset_dev_addr", dev_addr, 32'd0);
    chk("reset_dbe", 32'(dbe), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    #2 reset = 1'b0;

    foreach (vecs[i]) begin
      $display("vec %0d sel=%b addr=%h word=%h", i, vecs[i].sel, vecs[i].a, vecs[i].word);
      dm_load(vecs[i].sel, vecs[i].a, vecs[i].word, vecs[i].adel, vecs[i].exp);
    end

    // Back-to-back: second load issues in the cycle the first writes back.
    step();
    ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h20; #1;
    sb_q.push_back('{1'b0, 32'h1122_3344});
    step();
    ld_en = 1'b0; dm_rdata = 32'h1122_3344; #1;
    step();
    ld_en = 1'b1; ld_sel = 3'b001; addr = 32'h21; #1;
    chk("b2b_wb_valid_first", 32'(wb_valid), 32'd1);
    chk("b2b_stall_second", 32'(stall), 32'd1);
    sb_q.push_back('{1'b0, 32'h0000_00CC});
    step();
    ld_en = 1'b0; dm_rdata = 32'hAABB_CCDD; #1;
    chk("b2b_stall_T1", 32'(stall), 32'd1);
    step(); #1;
    chk("b2b_wb_valid_second", 32'(wb_valid), 32'd1);

    $display("device lw, ready in third wait cycle");
    dev_lw(2, 32'hDEAD_BEEF);
    dm_load(3'b010, 32'h7F00_0004, 32'h0, 1'b1, 32'h0);
    $display("device lw, timeout");
    dev_lw(-1, 32'h0);
    $display("device lw, ready on last wait cycle");
    dev_lw(TO - 1, 32'h1234_5678);

    $display("flush in DEV_WAIT");
    step();
    ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h7F00_000C; #1;
    step();
    ld_en = 1'b0; #1;
    chk("flush_dev_req_before", 32'(dev_req), 32'd1);
    step();
    flush = 1'b1; #1;
    chk("flush_stall_in_wait", 32'(stall), 32'd1);
    step();
    flush = 1'b0; dev_ready = 1'b1; dev_rdata = 32'hFEED_FACE; #1;
    chk("flush_dev_req_after", 32'(dev_req), 32'd0);
    chk("flush_stall_after", 32'(stall), 32'd0);
    chk("flush_wb_valid_after", 32'(wb_valid), 32'd0);
    step();
    dev_ready = 1'b0; #1;
    chk("flush_wb_valid_late", 32'(wb_valid), 32'd0);
    chk("flush_dbe_late", 32'(dbe), 32'd0);
    chk("flush_wb_data_held", wb_data, 32'h1234_5678);

    $display("flush with misaligned and aligned requests");
    step();
    flush = 1'b1; ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h1; #1;
    chk("flush_misaligned_adel", 32'(adel), 32'd0);
    chk("flush_misaligned_stall", 32'(stall), 32'd0);
    addr = 32'h0; #1;
    chk("flush_aligned_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0; ld_en = 1'b0; #1;
    chk("flush_idle_stall", 32'(stall), 32'd0);

    $display("flush in DM_WAIT");
    step();
    ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h40; #1;
    step();
    ld_en = 1'b0; flush = 1'b1; dm_rdata = 32'hFFFF_0000; #1;
    chk("flush_dm_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0; #1;
    chk("flush_dm_wb_valid", 32'(wb_valid), 32'd0);
    chk("flush_dm_stall_after", 32'(stall), 32'd0);
    chk("flush_dm_wb_data_held", wb_data, 32'h1234_5678);

    $display("asynchronous reset mid DEV_WAIT");
    step();
    ld_en = 1'b1; ld_sel = 3'b000; addr = 32'h7F00_0008; #1;
    step();
    ld_en = 1'b0; #1;
    chk("rst_dev_req_before", 32'(dev_req), 32'd1);
    #5 reset = 1'b1;
    #1;
    chk("rst_dev_req_async", 32'(dev_req), 32'd0);
    chk("rst_stall_async", 32'(stall), 32'd0);
    chk("rst_wb_valid_async", 32'(wb_valid), 32'd0);
    chk("rst_wb_data_async", wb_data, 32'd0);
    chk("rst_dev_addr_async", dev_addr, 32'd0);
    #1 reset = 1'b0;
    dm_load(3'b000, 32'h10, 32'h0102_0304, 1'b0, 32'h0102_0304);

    step();
    step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
